// File: rtl/bbox_detect.sv
// Scans a raw BMP pixel array one byte per cycle and reports the bounding box
// of every pixel whose colour differs from the background by more than TOL.
module bbox_detect #(
  parameter int          WIDTH    = 100,
  parameter int          HEIGHT   = 100,
  parameter logic [31:0] PIX_BASE = 32'd0,
  parameter logic [7:0]  BG_R     = 8'hFF,
  parameter logic [7:0]  BG_G     = 8'hFF,
  parameter logic [7:0]  BG_B     = 8'hFF,
  parameter logic [7:0]  TOL      = 8'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        done,
  output logic [31:0] readAddr,
  output logic        rden,
  input  logic [15:0] readdata,
  output logic        found,
  output logic [10:0] xMin,
  output logic [10:0] xMax,
  output logic [10:0] yMin,
  output logic [10:0] yMax
);

  localparam logic [10:0] X_LAST = 11'(WIDTH - 1);
  localparam logic [10:0] Y_TOP  = 11'(HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, SCAN, LAST, DONE} state_t;

  state_t      state_reg, state_next;
  logic [1:0]  b_cnt;
  logic [10:0] x_cnt, r_cnt;
  logic [31:0] addr_reg;
  logic        tag_valid;
  logic [1:0]  b_tag;
  logic [10:0] x_tag, y_tag;
  logic        acc_reg;
  logic        found_reg;
  logic [10:0] xmin_reg, xmax_reg, ymin_reg, ymax_reg;

  logic        last_issue, start_scan;
  logic [7:0]  byte_val, bg_sel, byte_diff;
  logic        chan_fg, pix_fg;
  logic        unused_hi;

  assign unused_hi  = ^readdata[15:8];
  assign last_issue = (b_cnt == 2'd2) && (x_cnt == X_LAST) && (r_cnt == Y_TOP);
  assign start_scan = ((state_reg == IDLE) || (state_reg == DONE)) && start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE: if (start) state_next = SCAN;
      SCAN:       if (last_issue) state_next = LAST;
      LAST:       state_next = DONE;
      default:    state_next = IDLE;
    endcase
  end

  // Address generation: linear byte address plus carried (b, x, r) coordinates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_reg <= PIX_BASE;
      b_cnt    <= 2'd0;
      x_cnt    <= 11'd0;
      r_cnt    <= 11'd0;
    end else if (start_scan) begin
      addr_reg <= PIX_BASE;
      b_cnt    <= 2'd0;
      x_cnt    <= 11'd0;
      r_cnt    <= 11'd0;
    end else if (state_reg == SCAN) begin
      if (!last_issue) addr_reg <= addr_reg + 32'd1;
      if (b_cnt == 2'd2) begin
        b_cnt <= 2'd0;
        if (x_cnt == X_LAST) begin
          x_cnt <= 11'd0;
          r_cnt <= (r_cnt == Y_TOP) ? 11'd0 : r_cnt + 11'd1;
        end else begin
          x_cnt <= x_cnt + 11'd1;
        end
      end else begin
        b_cnt <= b_cnt + 2'd1;
      end
    end
  end

  // Tags trail the issued address by one cycle to line up with readdata.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_valid <= 1'b0;
      b_tag     <= 2'd0;
      x_tag     <= 11'd0;
      y_tag     <= 11'd0;
    end else begin
      tag_valid <= (state_reg == SCAN) && !start_scan;
      b_tag     <= b_cnt;
      x_tag     <= x_cnt;
      y_tag     <= Y_TOP - r_cnt;
    end
  end

  always_comb begin
    byte_val = readdata[7:0];
    case (b_tag)
      2'd0:    bg_sel = BG_B;
      2'd1:    bg_sel = BG_G;
      default: bg_sel = BG_R;
    endcase
    byte_diff = (byte_val >= bg_sel) ? (byte_val - bg_sel) : (bg_sel - byte_val);
    chan_fg   = (byte_diff > TOL);
    pix_fg    = acc_reg | chan_fg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg   <= 1'b0;
      found_reg <= 1'b0;
      xmin_reg  <= 11'd0;
      xmax_reg  <= 11'd0;
      ymin_reg  <= 11'd0;
      ymax_reg  <= 11'd0;
    end else if (start_scan) begin
      acc_reg   <= 1'b0;
      found_reg <= 1'b0;
      xmin_reg  <= 11'd0;
      xmax_reg  <= 11'd0;
      ymin_reg  <= 11'd0;
      ymax_reg  <= 11'd0;
    end else if (tag_valid) begin
      if (b_tag == 2'd2) begin
        acc_reg <= 1'b0;
        if (pix_fg) begin
          found_reg <= 1'b1;
          if (!found_reg) begin
            xmin_reg <= x_tag;
            xmax_reg <= x_tag;
            ymin_reg <= y_tag;
            ymax_reg <= y_tag;
          end else begin
            if (x_tag < xmin_reg) xmin_reg <= x_tag;
            if (x_tag > xmax_reg) xmax_reg <= x_tag;
            if (y_tag < ymin_reg) ymin_reg <= y_tag;
            if (y_tag > ymax_reg) ymax_reg <= y_tag;
          end
        end
      end else begin
        acc_reg <= pix_fg;
      end
    end
  end

  assign done     = (state_reg == DONE);
  assign rden     = (state_reg == SCAN);
  assign readAddr = addr_reg;
  assign found    = found_reg;
  assign xMin     = xmin_reg;
  assign xMax     = xmax_reg;
  assign yMin     = ymin_reg;
  assign yMax     = ymax_reg;

endmodule

// File: tb/tb_bbox_detect.sv
// Directed and randomised scans of a 4x3 image checked against a per-pixel
// bounding-box model; one-cycle synchronous memory model supplies readdata.
module tb_bbox_detect;
  localparam int W = 4;
  localparam int H = 3;
  localparam int N = 3 * W * H;
  localparam logic [7:0] TOLV = 8'd4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        done;
  logic [31:0] readAddr;
  logic        rden;
  logic [15:0] readdata = 16'h0;
  logic        found;
  logic [10:0] xMin, xMax, yMin, yMax;

  logic [7:0] mem [N];

  int n_cmp = 0;
  int n_err = 0;
  int scan_no = 0;

  logic        exp_found;
  logic [10:0] exp_xmin, exp_xmax, exp_ymin, exp_ymax;

  bbox_detect #(
    .WIDTH(W), .HEIGHT(H), .PIX_BASE(32'd0),
    .BG_R(8'hFF), .BG_G(8'hFF), .BG_B(8'hFF), .TOL(TOLV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .done(done),
    .readAddr(readAddr), .rden(rden), .readdata(readdata),
    .found(found), .xMin(xMin), .xMax(xMax), .yMin(yMin), .yMax(yMax)
  );

  always #5 clk = ~clk;

  // Upper byte is random so that any use of it shows up as a wrong result.
  always @(posedge clk) begin
    if (readAddr < 32'(N)) readdata <= {8'($urandom), mem[int'(readAddr)]};
    else                   readdata <= {8'($urandom), 8'h00};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: walk whole pixels, a pixel is foreground if any channel is
  // further than TOL from white; y counts from the top (last stored row).
  task automatic model();
    logic fg;
    int   d, y;
    exp_found = 1'b0;
    exp_xmin = '0; exp_xmax = '0; exp_ymin = '0; exp_ymax = '0;
    for (int r = 0; r < H; r++) begin
      for (int x = 0; x < W; x++) begin
        fg = 1'b0;
        for (int b = 0; b < 3; b++) begin
          d = 255 - int'(mem[r*W*3 + x*3 + b]);
          if (d > int'(TOLV)) fg = 1'b1;
        end
        if (fg) begin
          y = H - 1 - r;
          if (!exp_found) begin
            exp_found = 1'b1;
            exp_xmin = 11'(x); exp_xmax = 11'(x);
            exp_ymin = 11'(y); exp_ymax = 11'(y);
          end else begin
            if (x < int'(exp_xmin)) exp_xmin = 11'(x);
            if (x > int'(exp_xmax)) exp_xmax = 11'(x);
            if (y < int'(exp_ymin)) exp_ymin = 11'(y);
            if (y > int'(exp_ymax)) exp_ymax = 11'(y);
          end
        end
      end
    end
  endtask

  task automatic fill_bg();
    for (int i = 0; i < N; i++) mem[i] = 8'hFF;
  endtask

  task automatic set_pix(input int r, input int x, input logic [7:0] rr,
                         input logic [7:0] gg, input logic [7:0] bb);
    mem[r*W*3 + x*3 + 0] = bb;
    mem[r*W*3 + x*3 + 1] = gg;
    mem[r*W*3 + x*3 + 2] = rr;
  endtask

  task automatic run_scan(input bit pulse_mid);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("entry_done", 32'(done), 32'd0);
    chk("entry_found", 32'(found), 32'd0);
    chk("entry_xmax", 32'(xMax), 32'd0);
    chk("entry_ymax", 32'(yMax), 32'd0);
    for (int i = 0; i < N; i++) begin
      chk("scan_rden", 32'(rden), 32'd1);
      chk("scan_addr", readAddr, 32'(i));
      chk("scan_done", 32'(done), 32'd0);
      start = (pulse_mid && (i == 5 || i == 20)) ? 1'b1 : 1'b0;
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("last_rden", 32'(rden), 32'd0);
    chk("last_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    chk("done_at_n1", 32'(done), 32'd1);
    model();
    chk("found", 32'(found), 32'(exp_found));
    chk("xmin", 32'(xMin), 32'(exp_xmin));
    chk("xmax", 32'(xMax), 32'(exp_xmax));
    chk("ymin", 32'(yMin), 32'(exp_ymin));
    chk("ymax", 32'(yMax), 32'(exp_ymax));
    $display("scan %0d: found=%0d x=[%0d,%0d] y=[%0d,%0d] (model found=%0d x=[%0d,%0d] y=[%0d,%0d])",
             scan_no, found, xMin, xMax, yMin, yMax,
             exp_found, exp_xmin, exp_xmax, exp_ymin, exp_ymax);
    scan_no++;
  endtask

  task automatic chk_box(input string tag, input logic f, input int x0, input int x1,
                         input int y0, input int y1);
    chk({tag, "_found"}, 32'(found), 32'(f));
    chk({tag, "_xmin"}, 32'(xMin), 32'(x0));
    chk({tag, "_xmax"}, 32'(xMax), 32'(x1));
    chk({tag, "_ymin"}, 32'(yMin), 32'(y0));
    chk({tag, "_ymax"}, 32'(yMax), 32'(y1));
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    fill_bg();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rden", 32'(rden), 32'd0);
    chk("rst_addr", readAddr, 32'd0);
    chk_box("rst", 1'b0, 0, 0, 0, 0);
    rst_n = 1'b1;

    // All background
    run_scan(1'b0);
    chk_box("empty", 1'b0, 0, 0, 0, 0);

    // Single black pixel at r=0, x=2
    set_pix(0, 2, 8'h00, 8'h00, 8'h00);
    run_scan(1'b0);
    chk_box("single", 1'b1, 2, 2, 2, 2);

    // Done and result held while start stays low
    repeat (3) @(posedge clk);
    #1;
    chk("hold_done", 32'(done), 32'd1);
    chk("hold_xmin", 32'(xMin), 32'd2);

    // Two pixels spanning the box
    fill_bg();
    set_pix(2, 0, 8'h00, 8'h00, 8'h00);
    set_pix(1, 3, 8'h10, 8'h20, 8'h30);
    run_scan(1'b0);
    chk_box("two", 1'b1, 0, 3, 0, 1);

    // Tolerance boundary: diff 4 is background, diff 5 is foreground
    fill_bg();
    set_pix(0, 0, 8'hFF, 8'hFF, 8'hFB);
    set_pix(2, 1, 8'hFF, 8'hFA, 8'hFF);
    run_scan(1'b0);
    chk_box("tol", 1'b1, 1, 1, 0, 0);

    // Full frame foreground
    for (int i = 0; i < N; i++) mem[i] = 8'h00;
    run_scan(1'b0);
    chk_box("full", 1'b1, 0, W - 1, 0, H - 1);

    // Asynchronous reset on SCAN cycle 10
    fill_bg();
    set_pix(0, 0, 8'h00, 8'h00, 8'h00);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("pre_rst_found", 32'(found), 32'd1);
    chk("pre_rst_ymax", 32'(yMax), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_rden", 32'(rden), 32'd0);
    chk("mid_rst_addr", readAddr, 32'd0);
    chk_box("mid_rst", 1'b0, 0, 0, 0, 0);
    #1 rst_n = 1'b1;

    // Restart after reset, with start pulses mid-scan that must be ignored
    set_pix(1, 2, 8'h80, 8'hFF, 8'hFF);
    run_scan(1'b1);
    chk_box("after_rst", 1'b1, 0, 2, 1, 2);

    // Randomised images near the tolerance edge
    for (int k = 0; k < 8; k++) begin
      for (int p = 0; p < W * H; p++) begin
        if ($urandom_range(0, 2) == 0) begin
          for (int b = 0; b < 3; b++) mem[p*3 + b] = 8'(8'hFF - $urandom_range(0, 7));
        end else begin
          for (int b = 0; b < 3; b++) mem[p*3 + b] = 8'hFF;
        end
      end
      run_scan(k[0]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bbox_detect.md
Name: bbox_detect

Overview:
- Upstream neighbour of the cropping stage: scans the raw BMP pixel array in image memory and finds the bounding box of all non-background pixels.
- Produces xMin/xMax/yMin/yMax for the cropper, plus a found flag, with a start/done handshake.
- Uses the cropper's coordinates: x = column, y top-down; memory row r maps to y = HEIGHT-1-r.
- Byte address of a channel = PIX_BASE + r*WIDTH*3 + x*3 + b, where b=0 is B, b=1 is G, b=2 is R.

Parameters:
- WIDTH, 100, image width in pixels (1..2047).
- HEIGHT, 100, image height in pixels (1..2047).
- PIX_BASE, 0, byte address of the first pixel byte.
- BG_R / BG_G / BG_B, 8'hFF each, background colour channels.
- TOL, 0, per-channel tolerance; a channel is foreground when |byte - BG| > TOL.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- start  in  1  begin scan (level, sampled in IDLE/DONE)
- done  out  1  result valid; held until next start
- readAddr  out  32  memory byte address
- rden  out  1  read strobe, 1 while an address is issued
- readdata  in  16  memory data; bits [7:0] used, [15:8] ignored
- found  out  1  at least one foreground pixel exists
- xMin, xMax, yMin, yMax  out  11 each  bounding box (inclusive)

Behaviour:
- Reset (asynchronous, any time, including mid-scan):
  - state=IDLE; done=0, rden=0, readAddr=PIX_BASE, found=0, all bounds=0.
- States: IDLE, SCAN, LAST, DONE.
- IDLE/DONE:
  - start=1 at an edge -> SCAN.
  - On entry to SCAN: clear found, bounds and the linear index; drop done to 0.
  - start=0 -> stay; outputs held.
- SCAN lasts exactly N=3*WIDTH*HEIGHT cycles. Each cycle:
  - rden=1, readAddr=PIX_BASE+idx; idx increments by 1 (b, x, r counters carried, no row padding).
  - After issuing idx=N-1 -> LAST.
  - start is ignored while in SCAN/LAST.
- Memory latency is fixed at 1 cycle: readdata for the address issued in cycle n is sampled in cycle n+1.
  - (x, r, b) tags are pipelined one register to stay aligned with the data.
- Per-byte compare: diff = |readdata[7:0] - BG_chan(b)| > TOL, with BG_chan selected by the delayed b.
  - OR the diff flags over b=0,1,2. On the b=2 byte, fg = accumulated OR; then clear the accumulator.
- Bounds update on fg, registered at the end of the b=2 capture cycle, with y = HEIGHT-1-r:
  - If found=0: load xMin=xMax=x, yMin=yMax=y, and set found=1.
  - Else: xMin=min(xMin,x), xMax=max(xMax,x), yMin=min(yMin,y), yMax=max(yMax,y).
  - All comparisons are unsigned, 11-bit.
- LAST (1 cycle): rden=0; captures and evaluates the final byte -> DONE.
- DONE: done=1; found and bounds stable.
  - done first reads 1 exactly N+1 cycles after the first SCAN cycle.
- No foreground pixels: found=0, all bounds=0. The cropper must gate on found.
- Full-frame foreground: xMin=0, xMax=WIDTH-1, yMin=0, yMax=HEIGHT-1.
- Throughput: 1 byte/cycle; no stalls or back-pressure.

Test Plan:
- WIDTH=4, HEIGHT=3, all bytes 8'hFF; pulse start -> 36 SCAN cycles with readAddr 0..35 consecutive, rden=1, then LAST; done=1 on cycle 37; found=0; bounds all 0.
- Same image, pixel (r=0, x=2) = R00 G00 B00 -> found=1, xMin=xMax=2, yMin=yMax=2.
- Foreground at (r=2, x=0) and (r=1, x=3) -> xMin=0, xMax=3, yMin=0, yMax=1. Verify readAddr for (r=1, x=3, b=2) = 23.
- TOL=4, one pixel with B=8'hFB (diff 4) and another with G=8'hFA (diff 5) -> only the G pixel counts as foreground; bounds equal its coordinates.
- Assert rst_n=0 on SCAN cycle 10 -> done, found and bounds are 0 immediately (asynchronous), state IDLE. A new start produces correct results. start pulses during SCAN do not restart the count.
- After DONE, change the memory contents and reassert start -> done drops the next cycle, bounds clear, and the new result appears N+1 cycles later.
